// File: rtl/aes_pkg.sv
// Shared AES types, GF(2^8) xtime helper and the MixColumns engine FSM encoding.
// The inverse transform is compiled in only when MIX_COLUMNS_INV_EN is defined.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;
  typedef logic [7:0]   byte_t;

  localparam byte_t AES_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_t;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic byte_t xtime(input byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational single-column (Inv)MixColumns transform; row 0 is the MSB byte.
// Inverse coefficients are present only when MIX_COLUMNS_INV_EN is defined.
module mix_column_unit
  import aes_pkg::*;
(
  input  col_t i_col,
  input  logic i_inv,
  output col_t o_col
);

  byte_t w_a  [4];
  byte_t w_x2 [4];
  byte_t w_b  [4];
`ifdef MIX_COLUMNS_INV_EN
  byte_t w_x4 [4];
  byte_t w_x8 [4];
`else
  logic  w_unused_inv;
  assign w_unused_inv = i_inv;
`endif

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      w_a[r]  = i_col[31-8*r -: 8];
      w_x2[r] = xtime(w_a[r]);
`ifdef MIX_COLUMNS_INV_EN
      w_x4[r] = xtime(w_x2[r]);
      w_x8[r] = xtime(w_x4[r]);
`endif
    end
    // Row indices wrap mod 4 through the 2-bit cast.
    for (int r = 0; r < 4; r++) begin
      w_b[r] = w_x2[r] ^ w_x2[2'(r+1)] ^ w_a[2'(r+1)] ^ w_a[2'(r+2)] ^ w_a[2'(r+3)];
`ifdef MIX_COLUMNS_INV_EN
      if (i_inv) begin
        w_b[r] = (w_x8[r] ^ w_x4[r] ^ w_x2[r])
               ^ (w_x8[2'(r+1)] ^ w_x2[2'(r+1)] ^ w_a[2'(r+1)])
               ^ (w_x8[2'(r+2)] ^ w_x4[2'(r+2)] ^ w_a[2'(r+2)])
               ^ (w_x8[2'(r+3)] ^ w_a[2'(r+3)]);
      end
`endif
    end
  end

  assign o_col = {w_b[0], w_b[1], w_b[2], w_b[3]};

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative handshaked AES MixColumns engine, COLS_PER_CYCLE columns per BUSY cycle.
// Define MIX_COLUMNS_INV_EN to compile in the per-state InvMixColumns mode.
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int NGROUPS = 4 / COLS_PER_CYCLE;
  localparam int CW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  fsm_t          r_fsm;
  fsm_t          w_fsm_nxt;
  state_t        r_state;
  logic [CW-1:0] r_grp;
  logic          w_inv;
  logic          w_accept;
  logic          w_last;
  int            w_base;
  col_t          w_col_in  [COLS_PER_CYCLE];
  col_t          w_col_out [COLS_PER_CYCLE];

`ifdef MIX_COLUMNS_INV_EN
  logic r_inv;
  assign w_inv = r_inv;
`else
  logic w_unused_inv;
  assign w_unused_inv = in_inv;
  assign w_inv        = 1'b0;
`endif

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid/data are held stable by the source until that edge.
  assign in_ready  = (r_fsm == IDLE);
  assign out_valid = (r_fsm == DONE);
  assign out_data  = r_state;
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_grp == CW'(NGROUPS - 1));
  assign w_base    = int'(r_grp) * COLS_PER_CYCLE;

  for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_unit
    assign w_col_in[gi] = r_state[127 - 32*(w_base + gi) -: 32];
    mix_column_unit u_mix (
      .i_col (w_col_in[gi]),
      .i_inv (w_inv),
      .o_col (w_col_out[gi])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_fsm <= IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE:    if (w_accept) w_fsm_nxt = BUSY;
      BUSY:    if (w_last) w_fsm_nxt = DONE;
      DONE:    if (out_ready) w_fsm_nxt = IDLE;
      default: w_fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= '0;
      r_grp   <= '0;
`ifdef MIX_COLUMNS_INV_EN
      r_inv   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_state <= in_data;
      r_grp   <= '0;
`ifdef MIX_COLUMNS_INV_EN
      r_inv   <= in_inv;
`endif
    end else if (r_fsm == BUSY) begin
      // Mixed columns are written back in place over their source slots.
      for (int i = 0; i < COLS_PER_CYCLE; i++) begin
        r_state[127 - 32*(w_base + i) -: 32] <= w_col_out[i];
      end
      if (!w_last) r_grp <= r_grp + 1'b1;
    end
  end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter: one DUT per COLS_PER_CYCLE value against a GF(2^8) reference model.
module tb_mix_columns_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_data  [3];
  logic [127:0] in_data;
  logic         in_inv;

  int n_vec  = 0;
  int n_fail = 0;

  logic [127:0] exp_q0[$];
  logic [127:0] exp_q1[$];
  logic [127:0] exp_q2[$];

  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] COL_IN   = 128'hf20a225c_c6c6c6c6_2d26314c_db135345;
  localparam logic [127:0] COL_OUT  = 128'h9fdc589d_c6c6c6c6_4d7ebdf8_8e4da1bc;

  mix_columns_iter #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]));
  mix_columns_iter #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]));
  mix_columns_iter #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_data(out_data[2]));

  // ---------------- reference model ----------------
  // Carry-less product followed by reduction modulo 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (16'h011B << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] model_col(input logic [31:0] c, input bit inv);
    logic [7:0]  a    [4];
    logic [7:0]  coef [4];
    logic [7:0]  b;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) a[i] = c[31-8*i -: 8];
    if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int row = 0; row < 4; row++) begin
      b = '0;
      for (int j = 0; j < 4; j++) b = b ^ gmul(coef[j], a[(row + j) % 4]);
      r[31-8*row -: 8] = b;
    end
    return r;
  endfunction

  function automatic logic [127:0] model_state(input logic [127:0] s, input bit inv);
    logic [127:0] r;
    bit eff_inv;
`ifdef MIX_COLUMNS_INV_EN
    eff_inv = inv;
`else
    eff_inv = 1'b0;
`endif
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = model_col(s[127-32*c -: 32], eff_inv);
    return r;
  endfunction

  // ---------------- scoreboard helpers ----------------
  function automatic int q_size(input int k);
    case (k)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [127:0] q_front(input int k);
    case (k)
      0:       return exp_q0[0];
      1:       return exp_q1[0];
      default: return exp_q2[0];
    endcase
  endfunction

  task automatic q_push(input int k, input logic [127:0] v);
    case (k)
      0:       exp_q0.push_back(v);
      1:       exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  task automatic q_pop(input int k);
    case (k)
      0:       void'(exp_q0.pop_front());
      1:       void'(exp_q1.pop_front());
      default: void'(exp_q2.pop_front());
    endcase
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_num(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 5 : (k == 1) ? 3 : 2;
  endfunction

  // Compare process: every valid output cycle is checked against the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (out_valid[k]) begin
          if (q_size(k) == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL sb_unexpected dut%0d: got %h, required no output", k, out_data[k]);
          end else begin
            check($sformatf("sb_dut%0d", k), out_data[k], q_front(k));
            if (out_ready[k]) q_pop(k);
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input int k, input logic [127:0] d, input bit inv,
                      input logic [127:0] lit, input bit use_lit);
    int n;
    @(posedge clk);
    #1;
    in_data     = d;
    in_inv      = inv;
    in_valid[k] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready[k] && n < 50);
    if (!in_ready[k]) begin
      check_num($sformatf("accept_timeout_dut%0d", k), 0, 1);
      #1 in_valid[k] = 1'b0;
      return;
    end
    @(posedge clk);
    q_push(k, model_state(d, inv));
    #1;
    in_valid[k] = 1'b0;
    in_data     = ~d;
    in_inv      = ~inv;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid[k] && n < 50);
    check_num($sformatf("latency_dut%0d", k), n, lat_of(k));
    if (use_lit) check($sformatf("literal_dut%0d", k), out_data[k], lit);
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst     = 1'b0;
    in_data = '0;
    in_inv  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
    end
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_num($sformatf("reset_in_ready_dut%0d", k), int'(in_ready[k]), 1);
      check_num($sformatf("reset_out_valid_dut%0d", k), int'(out_valid[k]), 0);
      check($sformatf("reset_out_data_dut%0d", k), out_data[k], 128'h0);
    end

    // Pin the model against hand-computed values.
    check("model_fips", model_state(FIPS_IN, 1'b0), FIPS_OUT);
    check("model_f20a", 128'(model_col(32'hf20a225c, 1'b0)), 128'(32'h9fdc589d));
    check("model_c6c6", 128'(model_col(32'hc6c6c6c6, 1'b0)), 128'(32'hc6c6c6c6));
    check("model_2d26", 128'(model_col(32'h2d26314c, 1'b0)), 128'(32'h4d7ebdf8));
    check("model_db13_inv", 128'(model_col(32'h8e4da1bc, 1'b1)), 128'(32'hdb135345));

    // Forward FIPS state and inverse round trip, CPC = 1.
    send(0, FIPS_IN, 1'b0, FIPS_OUT, 1'b1);
`ifdef MIX_COLUMNS_INV_EN
    send(0, FIPS_OUT, 1'b1, FIPS_IN, 1'b1);
`else
    send(0, FIPS_IN, 1'b1, FIPS_OUT, 1'b1);
`endif
    drain();

    // Column vectors on every CPC, forward and (where built) back.
    for (int k = 0; k < 3; k++) begin
      send(k, COL_IN, 1'b0, COL_OUT, 1'b1);
`ifdef MIX_COLUMNS_INV_EN
      send(k, COL_OUT, 1'b1, COL_IN, 1'b1);
`endif
      drain();
    end

    // A few random states per CPC, random mode.
    for (int k = 0; k < 3; k++) begin
      for (int t = 0; t < 3; t++) begin
        send(k, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)), '0, 1'b0);
      end
      drain();
    end

    // Backpressure: stall 10 cycles in DONE with a competing in_valid.
    out_ready[0] = 1'b0;
    send(0, FIPS_IN, 1'b0, FIPS_OUT, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      in_valid[0] = 1'b1;
      in_data     = COL_IN;
      in_inv      = 1'b0;
      @(negedge clk);
      check_num("stall_in_ready", int'(in_ready[0]), 0);
      check("stall_out_data", out_data[0], FIPS_OUT);
    end
    @(posedge clk);
    #1;
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_num("post_hs_in_ready", int'(in_ready[0]), 1);
    check_num("post_hs_out_valid", int'(out_valid[0]), 0);
    drain();

    // Reset with dut1 stalled in DONE and dut0 two groups into BUSY.
    out_ready[1] = 1'b0;
    send(1, COL_IN, 1'b0, COL_OUT, 1'b1);
    @(posedge clk);
    #1;
    in_data     = FIPS_IN;
    in_inv      = 1'b0;
    in_valid[0] = 1'b1;
    @(negedge clk);
    check_num("rst_pre_in_ready", int'(in_ready[0]), 1);
    @(posedge clk);
    q_push(0, model_state(FIPS_IN, 1'b0));
    #1 in_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      check_num($sformatf("async_rst_out_valid_dut%0d", k), int'(out_valid[k]), 0);
      check($sformatf("async_rst_out_data_dut%0d", k), out_data[k], 128'h0);
      check_num($sformatf("async_rst_in_ready_dut%0d", k), int'(in_ready[k]), 1);
    end
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
    out_ready[1] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    send(0, FIPS_IN, 1'b0, FIPS_OUT, 1'b1);
    send(1, COL_IN, 1'b0, COL_OUT, 1'b1);
    drain();

    for (int k = 0; k < 3; k++) check_num($sformatf("queue_empty_dut%0d", k), q_size(k), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
